// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions: divider FSM states, default
// operand width and the step-counter width helper.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 4;

  // Counter must hold the values 0..width, one slot per quotient bit
  function automatic int div_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DIV_CNT_W = div_cnt_width(DIV_WIDTH_DEFAULT);

endpackage

// File: rtl/div_step.sv
// Single restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, emit the quotient bit.
module div_step
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_next,
  output logic             q_bit
);

  logic [WIDTH:0] t;
  logic [WIDTH:0] d_ext;

  // Trial subtraction; the partial remainder never exceeds WIDTH+1 bits
  always_comb begin
    t      = {r[WIDTH-1:0], q_msb};
    d_ext  = {1'b0, d};
    r_next = t;
    q_bit  = 1'b0;
    if (t >= d_ext) begin
      r_next = t - d_ext;
      q_bit  = 1'b1;
    end else begin
      r_next = t;
      q_bit  = 1'b0;
    end
  end

endmodule

// File: rtl/seq_div_4bit.sv
// Sequential unsigned restoring divider with start/done handshake.
// One quotient bit per clock; divide-by-zero short-circuits to DONE.
// WIDTH must be at least 2.
module seq_div_4bit
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = div_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_t       state;
  div_state_t       next_state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH:0]   r;
  logic [CW-1:0]    cnt;
  logic             dz_flag;
  logic             accept;
  logic             last_step;
  logic [WIDTH:0]   r_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_shift;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r),
    .q_msb  (q[WIDTH-1]),
    .d      (d),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  assign q_shift = {q[WIDTH-2:0], q_bit};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus the accept/last-step strobes used by the datapath
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = (b == {WIDTH{1'b0}}) ? DONE : RUN;
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (cnt == LAST_STEP) begin
          last_step  = 1'b1;
          next_state = DONE;
        end else begin
          next_state = RUN;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs; results land on RUN->DONE, or on
  // DONE->IDLE for the divide-by-zero case so the flag rises with done
  always_ff @(posedge clk) begin
    if (rst) begin
      q           <= {WIDTH{1'b0}};
      d           <= {WIDTH{1'b0}};
      r           <= {(WIDTH+1){1'b0}};
      cnt         <= {CW{1'b0}};
      dz_flag     <= 1'b0;
      quot        <= {WIDTH{1'b0}};
      rem         <= {WIDTH{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (next_state != IDLE);
      done <= (state == DONE);
      if (accept) begin
        q           <= a;
        d           <= b;
        r           <= {(WIDTH+1){1'b0}};
        cnt         <= {CW{1'b0}};
        dz_flag     <= (b == {WIDTH{1'b0}});
        div_by_zero <= 1'b0;
      end else if (state == RUN) begin
        q   <= q_shift;
        r   <= r_next;
        cnt <= cnt + CW'(1);
        if (last_step) begin
          quot <= q_shift;
          rem  <= r_next[WIDTH-1:0];
        end
      end else if ((state == DONE) && dz_flag) begin
        quot        <= {WIDTH{1'b1}};
        rem         <= q;
        div_by_zero <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_div_4bit.sv
// Scoreboard bench for seq_div_4bit: stimulus pushes expected results from
// an arithmetic reference model; an independent monitor checks every done.
module tb_seq_div_4bit;

  localparam int W = 4;

  typedef struct {
    int q;
    int r;
    int dz;
    int due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_done = 0;
  logic prev_done = 1'b0;

  seq_div_4bit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .quot        (quot),
    .rem         (rem),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      n_done++;
      chk("done_single_cycle", int'(prev_done), 0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("quot", int'(quot), e.q);
        chk("rem", int'(rem), e.r);
        chk("div_by_zero", int'(div_by_zero), e.dz);
        chk("done_latency", cyc, e.due);
      end
    end
    prev_done = done;
  end

  // Issue one division from a negedge; returns at the negedge after the accept edge
  task automatic issue(input int av, input int bv);
    exp_t e;
    a     = W'(av);
    b     = W'(bv);
    start = 1'b1;
    if (bv == 0) begin
      e.q  = (1 << W) - 1;
      e.r  = av;
      e.dz = 1;
      e.due = cyc + 2;
    end else begin
      e.q  = av / bv;
      e.r  = av % bv;
      e.dz = 0;
      e.due = cyc + W + 2;
    end
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) until the divider drops busy
  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    if (busy) chk("busy_timeout", 1, 0);
  endtask

  task automatic run(input int av, input int bv);
    issue(av, bv);
    wait_idle();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_quot", int'(quot), 0);
    chk("rst_rem", int'(rem), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic case with hold check after the done pulse
    run(13, 4);
    @(negedge clk);
    chk("hold_done_low", int'(done), 0);
    chk("hold_quot", int'(quot), 3);
    chk("hold_rem", int'(rem), 1);

    run(15, 1);
    run(7, 9);
    run(0, 5);
    run(15, 15);
    run(9, 0);
    run(8, 2);

    // start while busy must be ignored
    issue(14, 3);
    a = 4'd6;
    b = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    // Reset on the third RUN edge aborts the operation
    issue(11, 2);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    chk("abort_quot", int'(quot), 0);
    chk("abort_rem", int'(rem), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_dbz", int'(div_by_zero), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    run(11, 2);

    // Exhaustive sweep
    for (int i = 0; i < 256; i++) begin
      run(i >> 4, i & 15);
    end

    // Random pairs
    for (int i = 0; i < 40; i++) begin
      run(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("done_count", n_done, 1 + 6 + 1 + 1 + 256 + 40);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
